// File: rtl/dda_ctrl_pkg.sv
// dda_ctrl_pkg: shared state encoding and sample-stream constants for the DDA run controller
package dda_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;
  localparam int SAMPLE_BYTES = 4;
  localparam int BIDX_W = $clog2(SAMPLE_BYTES);
endpackage

// File: rtl/dda_sample_serializer.sv
// dda_sample_serializer: parallel-load shift buffer streaming one {x,y} sample MSB byte first
module dda_sample_serializer import dda_ctrl_pkg::*; #(
  parameter int W = 8 * SAMPLE_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  output logic [7:0]   out_data_o,
  output logic         out_valid_o,
  output logic         free_o
);
  logic [W-1:0]      sr_q;
  logic [BIDX_W-1:0] idx_q;
  logic              valid_q;
  logic              last;
  // free already in the cycle the final byte handshakes, so a new sample can follow without a bubble
  assign last = valid_q && out_ready_i && idx_q == BIDX_W'(SAMPLE_BYTES - 1);
  assign free_o = !valid_q || last;
  assign out_data_o = sr_q[W-1 -: 8];
  assign out_valid_o = valid_q;
  // load has priority over shifting; flush drops a partly sent sample
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sr_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      sr_q <= data_i;
      idx_q <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready_i) begin
      sr_q <= sr_q << 8;
      idx_q <= idx_q + BIDX_W'(1);
      valid_q <= !last;
    end
  end
endmodule

// File: rtl/dda_run_ctrl.sv
// dda_run_ctrl: sequences the DDA core, decimates its (x,y) trajectory and streams samples as bytes
module dda_run_ctrl import dda_ctrl_pkg::*; #(
  parameter int N = 16,
  parameter int STEP_W = 16,
  parameter int DEC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [DEC_W-1:0]  decim,
  output logic              core_en,
  output logic              core_rst,
  input  logic [N-1:0]      core_x,
  input  logic [N-1:0]      core_y,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);
  state_t            state_q;
  logic [STEP_W-1:0] step_q, nsteps_q;
  logic [DEC_W-1:0]  dec_q, dfac_q, dec_inc, dec_nxt;
  logic              pend_q, done_q;
  logic              ser_free, ser_load, cap, step, last;
  // a step that must capture waits for the buffer; otherwise the core steps every RUN cycle
  assign cap = dec_q == '0;
  assign step = state_q == RUN && !(cap && !ser_free);
  assign dec_inc = dec_q + DEC_W'(1);
  assign dec_nxt = dec_inc == dfac_q ? '0 : dec_inc;
  assign last = nsteps_q != '0 && step_q + STEP_W'(1) == nsteps_q;
  assign ser_load = (step && cap) || (state_q == DRAIN && pend_q && ser_free);
  assign core_en = state_q == LOAD || step;
  assign core_rst = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign step_cnt = step_q;
  dda_sample_serializer #(.W(2 * N)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (abort),
    .load_i      (ser_load),
    .data_i      ({core_x, core_y}),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .free_o      (ser_free)
  );
  // run sequencer: run parameters latched at start, done raised as the FSM returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      nsteps_q <= '0;
      dec_q <= '0;
      dfac_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start && !done_q) begin
          state_q <= LOAD;
          nsteps_q <= num_steps;
          dfac_q <= decim == '0 ? DEC_W'(1) : decim;
          step_q <= '0;
          dec_q <= '0;
        end
        LOAD: state_q <= RUN;
        RUN: if (step) begin
          step_q <= step_q + STEP_W'(1);
          dec_q <= dec_nxt;
          if (last) begin
            state_q <= DRAIN;
            pend_q <= dec_nxt == '0;
          end
        end
        DRAIN: if (pend_q) begin
          if (ser_free) pend_q <= 1'b0;
        end else if (ser_free) begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dda_run_ctrl.sv
// tb_dda_run_ctrl: directed table-driven bench with a stub DDA core driven by core_en/core_rst
module tb_dda_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [15:0] num_steps = '0;
  logic [7:0]  decim = '0;
  logic        core_en, core_rst, out_valid, busy, done;
  logic [7:0]  out_data;
  logic [15:0] step_cnt;
  logic [15:0] core_x = '0, core_y = '0;
  logic        w_start = 1'b0, w_abort = 1'b0, w_ready = 1'b1;
  logic [3:0]  w_num_steps = '0;
  logic [7:0]  w_decim = 8'd1;
  logic        w_en, w_rst, w_valid, w_busy, w_done;
  logic [7:0]  w_data;
  logic [3:0]  w_step_cnt;
  logic [15:0] w_x = '0, w_y = '0;
  dda_run_ctrl #(.N(16), .STEP_W(16), .DEC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps), .decim(decim),
    .core_en(core_en), .core_rst(core_rst), .core_x(core_x), .core_y(core_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );
  dda_run_ctrl #(.N(16), .STEP_W(4), .DEC_W(8)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .num_steps(w_num_steps), .decim(w_decim),
    .core_en(w_en), .core_rst(w_rst), .core_x(w_x), .core_y(w_y),
    .out_data(w_data), .out_valid(w_valid), .out_ready(w_ready),
    .busy(w_busy), .done(w_done), .step_cnt(w_step_cnt)
  );
  // stub cores: load (0x0010, 0xFF00) on en&rst, else x+1 / y-1 per enabled cycle
  always @(posedge clk) begin
    if (core_en) begin
      core_x <= core_rst ? 16'h0010 : core_x + 16'd1;
      core_y <= core_rst ? 16'hFF00 : core_y - 16'd1;
    end
    if (w_en) begin
      w_x <= w_rst ? 16'h0010 : w_x + 16'd1;
      w_y <= w_rst ? 16'hFF00 : w_y - 16'd1;
    end
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [15:0]  ns;
    logic [7:0]   dc;
    bit           slow;
    bit           restart;
    int           nb;
    logic [127:0] bytes;
  } vec_t;
  vec_t tbl[5];
  task automatic run_vec(input int v);
    int en_n = 0, ld_n = 0, dd, mdec;
    bit fin = 0, stall_bad = 0;
    logic [7:0] got[$];
    logic [7:0] b;
    num_steps = tbl[v].ns;
    decim = tbl[v].dc;
    dd = tbl[v].dc == 0 ? 1 : int'(tbl[v].dc);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      start = c == 0 || (tbl[v].restart && c == 6);
      if (tbl[v].restart && c == 6) begin
        num_steps = 16'd9;
        decim = 8'd1;
      end
      out_ready = tbl[v].slow ? c % 3 == 0 : 1'b1;
      #1;
      mdec = en_n % dd;
      if (ld_n == 1 && !core_rst && en_n < int'(tbl[v].ns) && mdec == 0 && out_valid &&
          !(out_ready && got.size() % 4 == 3) && core_en) stall_bad = 1;
      if (core_en && core_rst) ld_n++;
      if (core_en && !core_rst) en_n++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) begin
        fin = 1;
        chk($sformatf("v%0d busy_at_done", v), busy, 0);
        chk($sformatf("v%0d step_cnt_at_done", v), step_cnt, tbl[v].ns);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("v%0d done_seen", v), fin, 1);
    chk($sformatf("v%0d load_cycles", v), ld_n, 1);
    chk($sformatf("v%0d step_cycles", v), en_n, tbl[v].ns);
    chk($sformatf("v%0d stall", v), stall_bad, 0);
    chk($sformatf("v%0d byte_count", v), got.size(), tbl[v].nb);
    for (int i = 0; i < tbl[v].nb; i++) begin
      b = i < got.size() ? got[i] : 8'hxx;
      chk($sformatf("v%0d byte%0d", v, i), b, tbl[v].bytes[127 - 8 * i -: 8]);
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d done_single", v), done, 0);
  endtask
  initial begin
    int en_n, wn;
    bit hit, dn, wrapped;
    logic [7:0] wq[$];
    tbl[0] = '{16'd4, 8'd2, 1'b0, 1'b0, 12, 128'h0010FF00_0012FEFE_0014FEFC_00000000};
    tbl[1] = '{16'd4, 8'd2, 1'b1, 1'b0, 12, 128'h0010FF00_0012FEFE_0014FEFC_00000000};
    tbl[2] = '{16'd3, 8'd0, 1'b0, 1'b0, 16, 128'h0010FF00_0011FEFF_0012FEFE_0013FEFD};
    tbl[3] = '{16'd4, 8'd2, 1'b0, 1'b1, 12, 128'h0010FF00_0012FEFE_0014FEFC_00000000};
    tbl[4] = '{16'd1, 8'd1, 1'b0, 1'b0, 8, 128'h0010FF00_0011FEFF_00000000_00000000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {core_en, core_rst, out_valid, out_data, busy, done, step_cnt}, 0);
    chk("reset_outputs_w", {w_en, w_rst, w_valid, w_data, w_busy, w_done, w_step_cnt}, 0);
    for (int v = 0; v < 4; v++) run_vec(v);
    // abort mid-sample after 5 steps
    num_steps = 16'd20;
    decim = 8'd1;
    en_n = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = c == 0;
      #1;
      if (core_en && !core_rst) en_n++;
      hit = en_n == 5;
    end
    start = 1'b0;
    chk("abort_reached_5_steps", hit, 1);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    #1;
    chk("abort_mid_sample_valid", out_valid, 1);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    #1;
    chk("abort_next_cycle", {core_en, core_rst, out_valid, busy}, 0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      dn = dn | done | busy;
    end
    chk("abort_no_done_no_restart", dn, 0);
    run_vec(4);
    // synchronous reset in the middle of a run
    num_steps = 16'd20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_run", {core_en, core_rst, out_valid, out_data, busy, done, step_cnt}, 0);
    run_vec(2);
    // free-run with a 4-bit step counter: wrap after 16 steps, stream keeps going
    wn = 0;
    wrapped = 0;
    for (int c = 0; c < 400 && wq.size() < 68; c++) begin
      @(negedge clk);
      w_start = c == 0;
      #1;
      if (wn == 16 && !wrapped) begin
        wrapped = 1;
        chk("wrap_step_cnt", w_step_cnt, 0);
        chk("wrap_busy", w_busy, 1);
      end
      if (w_en && !w_rst) wn++;
      if (w_valid && w_ready) wq.push_back(w_data);
    end
    w_start = 1'b0;
    chk("wrap_seen", wrapped, 1);
    chk("wrap_bytes", wq.size() >= 68, 1);
    if (wq.size() >= 68) chk("wrap_sample16", {wq[64], wq[65], wq[66], wq[67]}, 32'h0020FEF0);
    @(negedge clk);
    w_abort = 1'b1;
    @(negedge clk);
    w_abort = 1'b0;
    #1;
    chk("w_abort", {w_en, w_valid, w_busy, w_done}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dda_run_ctrl.md
Name: dda_run_ctrl

Overview:
Run controller and sample streamer for the Van der Pol posit DDA core (`dda`). It does three jobs:
- sequences the core's `en`/`rst` pins to load initial conditions and then step the integrators for a programmed number of Euler steps;
- decimates the (x, y) state trajectory;
- serialises each kept sample as 4 bytes over a valid/ready byte stream toward the chip's 8-bit output pins.

Output backpressure stalls integration, so no sample is ever lost.

Parameters:
- N, 16, posit width of core_x/core_y.
- STEP_W, 16, width of the step counter and num_steps.
- DEC_W, 8, width of the decimation factor.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  terminates a run immediately.
- num_steps  in  STEP_W  Euler steps per run; 0 = free-run until abort.
- decim  in  DEC_W  keep one sample every decim steps; 0 is treated as 1.
- core_en  out  1  drives dda.en; one integration step per cycle while high.
- core_rst  out  1  drives dda.rst; the core honours it only when core_en is also high.
- core_x  in  N  dda.x (registered state).
- core_y  in  N  dda.y (registered state).
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte.
- busy  out  1  high in LOAD/RUN/DRAIN.
- done  out  1  one-cycle pulse at normal run completion.
- step_cnt  out  STEP_W  steps taken since load.

Behaviour:
- Reset (clk edge with rst=1, in any state): state=IDLE. All outputs 0: core_en, core_rst, out_valid, out_data, busy, done, step_cnt. Counters and sample buffer are cleared.
- Effective decimation: D = (decim==0) ? 1 : decim. D and num_steps are latched on start; later input changes have no effect until the next start.
- Sample buffer: a 32-bit shift buffer holding {x, y}.
  - Bytes are emitted in the order x[15:8], x[7:0], y[15:8], y[7:0].
  - out_valid and out_data are held stable until out_ready=1.
  - The buffer reads "free" in the cycle its 4th byte handshakes, so back-to-back samples have no bubble.
- States:
  - IDLE: core_en=0. A start pulse moves to LOAD. Start pulses while busy are ignored.
  - LOAD (exactly 1 cycle): core_en=1, core_rst=1, so the core state becomes (icx, icy). step_cnt=0, dec_cnt=0. Next state RUN.
  - RUN: core_en=1 unless stalled.
    - A step taken with dec_cnt==0 first captures the current (core_x, core_y) into the buffer; that is the pre-step state k.
    - If dec_cnt==0 and the buffer is not free, core_en=0 (stall) and no counters change.
    - Each step: step_cnt+1; dec_cnt = (dec_cnt+1) mod D.
    - When num_steps!=0 and the step that makes step_cnt==num_steps is taken, the next state is DRAIN.
  - DRAIN: core_en=0.
    - If dec_cnt==0, capture the final state once, when the buffer is free.
    - Then wait for the buffer to be empty. Pulse done for 1 cycle, then go to IDLE.
- Sample count per finite run: floor(num_steps/D) + 1. The run covers states 0, D, 2D, …, num_steps rounded down to a multiple of D.
- Free-run (num_steps==0): never enters DRAIN. step_cnt wraps modulo 2^STEP_W; wrap has no other effect.
- abort (any state, highest priority after rst): next state IDLE.
  - core_en=0 and core_rst=0 on the next cycle.
  - Buffer is flushed and out_valid drops, possibly mid-sample; the sink must resynchronise on a new start.
  - No done pulse.
  - start in the same cycle as abort is ignored.
- busy = state != IDLE. done is never asserted together with busy=0 in the same cycle as a new start being accepted.
- core_rst is high only in LOAD.

Decomposition:
- Shared package dda_ctrl_pkg:
  - state encoding localparams IDLE/LOAD/RUN/DRAIN;
  - SAMPLE_BYTES=4;
  - byte-index width.
- One natural sub-module: dda_sample_serializer. It provides a 2N-bit parallel load, a free flag, and an 8-bit valid/ready output. The FSM and counters stay in dda_run_ctrl.

Test Plan:
The bench replaces dda with a stub: on en&rst, x=0x0010 and y=0xFF00; on en alone, x+=1 and y-=1.
1. num_steps=4, decim=2, out_ready=1, start:
   - one LOAD cycle with core_rst=core_en=1, then 4 core_en cycles;
   - 12 bytes: 00 10 FF 00 / 00 12 FE FE / 00 14 FE FC;
   - done pulses once, step_cnt=4, busy falls with done.
2. Same setup, out_ready toggling 1 of 3 cycles:
   - identical 12-byte sequence;
   - core_en low while dec_cnt==0 and buffer busy;
   - no capture lost or duplicated.
3. decim=0, num_steps=3 → 16 bytes (x=0x10..0x13), i.e. behaves as D=1.
4. abort in RUN after 5 steps with a sample mid-transfer:
   - next cycle core_en=0, out_valid=0, busy=0;
   - no done pulse;
   - a subsequent start reloads x=0x0010.
5. STEP_W=4, num_steps=0, decim=1: after 16 steps step_cnt wraps to 0, core_en stays high, and the stream continues (x=0x0020).
6. start while busy is ignored (run length unchanged). rst mid-RUN → all outputs 0 next cycle, state IDLE.
